// File: rtl/demux_router.sv
// demux_router
//   Fans one WIDTH-bit input stream out to two sink ports, A and B.
//   In IDLE a word is accepted when either sink requests; the destination is
//   the only requester, or on a tie the sink not served last (round-robin via
//   sel_last). The word is then held on out_X/valid_X until ack_X, after which
//   the block returns to IDLE and bumps that sink's delivery counter.
//
// Ports:
//   clk, rstN          clock (rising edge), synchronous active-low reset
//   data_in, in_valid  upstream word and its valid flag
//   in_ready           combinational accept: IDLE and at least one request
//   req_a, req_b       sink request flags
//   out_a, out_b       registered words for each sink (kept after delivery)
//   valid_a, valid_b   undelivered word present (never both set)
//   ack_a, ack_b       sink consumed its word
//   sel_last           destination of last transfer (0 = A, 1 = B)
//   cnt_a, cnt_b       wrapping per-sink delivery counters
module demux_router #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             req_a,
    input  logic             req_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             valid_a,
    output logic             valid_b,
    input  logic             ack_a,
    input  logic             ack_b,
    output logic             sel_last,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   xfer;
    logic   to_b;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        xfer      = 1'b0;
        // Tie between both requesters goes to the sink not served last.
        to_b      = req_b & (~req_a | ~sel_last);
        case (state)
            IDLE: begin
                in_ready = req_a | req_b;
                xfer     = in_valid & in_ready;
                if (xfer) begin
                    state_nxt = to_b ? HOLD_B : HOLD_A;
                end
            end
            HOLD_A: begin
                if (ack_a) begin
                    state_nxt = IDLE;
                end
            end
            HOLD_B: begin
                if (ack_b) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= IDLE;
            out_a    <= '0;
            out_b    <= '0;
            valid_a  <= 1'b0;
            valid_b  <= 1'b0;
            sel_last <= 1'b1;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sel_last <= to_b;
                        if (to_b) begin
                            out_b   <= data_in;
                            valid_b <= 1'b1;
                        end else begin
                            out_a   <= data_in;
                            valid_a <= 1'b1;
                        end
                    end
                end
                HOLD_A: begin
                    if (ack_a) begin
                        valid_a <= 1'b0;
                        cnt_a   <= cnt_a + CNT_W'(1);
                    end
                end
                HOLD_B: begin
                    if (ack_b) begin
                        valid_b <= 1'b0;
                        cnt_b   <= cnt_b + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
